// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: six-digit multiplexed seven-segment scan controller.
// Digit values are written into a shadow bank and copied to the active bank
// in a one-cycle COMMIT slot at a frame boundary, so a frame never shows a
// half-updated display. Each digit slot is followed by an all-off guard
// interval to avoid ghosting on the digit drivers.
// Optional feature: define SEG_SCAN_DP_EN to add the decimal-point
// input dp_mask[5:0] and the active-low registered output dp.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned GUARD_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic       wr_ready,
  input  logic       commit_req,
  output logic       commit_ack,
  input  logic [5:0] blank_mask,
  output logic [6:0] seg,
  output logic [5:0] sel
`ifdef SEG_SCAN_DP_EN
  ,
  input  logic [5:0] dp_mask,
  output logic       dp
`endif
);

  localparam int unsigned NDIG    = 6;
  localparam int unsigned MAX_DIV = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int unsigned PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD_CYC - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NDIG - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;
  localparam logic [5:0]    SEL_OFF    = 6'h3F;

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_GUARD  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_idx;
  logic [PW-1:0] r_pre;
  logic          r_pending;
  logic [3:0]    r_shadow [NDIG];
  logic [3:0]    r_active [NDIG];
  logic [6:0]    r_seg;
  logic [5:0]    r_sel;
  logic          r_ack;

  state_t        w_state_nxt;
  logic [2:0]    w_idx_nxt;
  logic [PW-1:0] w_pre_nxt;
  logic          w_pend_nxt;
  logic          w_commit;
  logic [6:0]    w_seg_nxt;
  logic [5:0]    w_sel_nxt;
  logic          w_ack_nxt;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic          w_wr_ready;
  logic          w_wr_acc;

`ifdef SEG_SCAN_DP_EN
  logic r_dp;
  logic w_dp_nxt;
  logic w_dpm;
`endif

  // Active-low seven-segment decode, bit6 = a .. bit0 = g
  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Writes are refused during reset and during the commit slot
  assign w_wr_ready = !rst && (r_state != ST_COMMIT);
  assign w_wr_acc   = wr_en && w_wr_ready && (wr_addr <= IDX_LAST);
  assign wr_ready   = w_wr_ready;

  // Pick the active digit and its live mask bits for the current slot
  always_comb begin
    w_digit = 4'h0;
    w_blank = 1'b0;
`ifdef SEG_SCAN_DP_EN
    w_dpm   = 1'b0;
`endif
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == 3'(i)) begin
        w_digit = r_active[i];
        w_blank = blank_mask[i];
`ifdef SEG_SCAN_DP_EN
        w_dpm   = dp_mask[i];
`endif
      end
    end
  end

  // Next-state and next-output logic for the scan sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pre_nxt   = r_pre;
    w_pend_nxt  = r_pending | commit_req;
    w_commit    = 1'b0;
    w_seg_nxt   = SEG_OFF;
    w_sel_nxt   = SEL_OFF;
    w_ack_nxt   = 1'b0;
`ifdef SEG_SCAN_DP_EN
    w_dp_nxt    = 1'b1;
`endif
    case (r_state)
      ST_SCAN: begin
        w_sel_nxt = ~(6'b000001 << r_idx);
        if (!w_blank) w_seg_nxt = f_decode(w_digit);
`ifdef SEG_SCAN_DP_EN
        w_dp_nxt  = ~w_dpm;
`endif
        if (r_pre == SCAN_LAST) begin
          w_state_nxt = ST_GUARD;
          w_pre_nxt   = '0;
        end else begin
          w_pre_nxt   = r_pre + PW'(1);
        end
      end
      ST_GUARD: begin
        if (r_pre == GUARD_LAST) begin
          w_pre_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = 3'd0;
            w_state_nxt = r_pending ? ST_COMMIT : ST_SCAN;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = ST_SCAN;
          end
        end else begin
          w_pre_nxt = r_pre + PW'(1);
        end
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_ack_nxt   = 1'b1;
        w_pend_nxt  = commit_req;
        w_idx_nxt   = 3'd0;
        w_pre_nxt   = '0;
        w_state_nxt = ST_SCAN;
      end
      default: begin
        w_idx_nxt   = 3'd0;
        w_pre_nxt   = '0;
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

  // Sequencer state and registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_SCAN;
      r_idx     <= 3'd0;
      r_pre     <= '0;
      r_pending <= 1'b0;
      r_seg     <= SEG_OFF;
      r_sel     <= SEL_OFF;
      r_ack     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pre     <= w_pre_nxt;
      r_pending <= w_pend_nxt;
      r_seg     <= w_seg_nxt;
      r_sel     <= w_sel_nxt;
      r_ack     <= w_ack_nxt;
    end
  end

  // Shadow bank takes host writes; active bank changes only on commit
  always_ff @(posedge clk) begin
    for (int i = 0; i < NDIG; i++) begin
      if (rst) begin
        r_shadow[i] <= 4'h0;
        r_active[i] <= 4'h0;
      end else begin
        if (w_wr_acc && (wr_addr == 3'(i))) r_shadow[i] <= wr_data;
        if (w_commit) r_active[i] <= r_shadow[i];
      end
    end
  end

`ifdef SEG_SCAN_DP_EN
  // Decimal point follows the scanned digit, off outside SCAN
  always_ff @(posedge clk) begin
    if (rst) r_dp <= 1'b1;
    else     r_dp <= w_dp_nxt;
  end
  assign dp = r_dp;
`endif

  assign seg        = r_seg;
  assign sel        = r_sel;
  assign commit_ack = r_ack;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (SCAN_DIV=4, GUARD_CYC=1): a cycle model pushes the
// expected pin values at every rising edge, the monitor pops and compares on
// the falling edge; directed checks cover commit, blanking and reset abort.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int GUARD_CYC = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_ready;
  logic       commit_req = 1'b0;
  logic       commit_ack;
  logic [5:0] blank_mask = 6'd0;
  logic [6:0] seg;
  logic [5:0] sel;

  typedef struct {
    logic [6:0] seg;
    logic [5:0] sel;
    logic       ack;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ack_cnt = 0;

  // model state: 0 scan, 1 guard, 2 commit
  int         m_st = 0;
  int         m_d  = 0;
  int         m_t  = 0;
  logic       m_pend = 1'b0;
  logic [3:0] m_sh  [6];
  logic [3:0] m_act [6];

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .GUARD_CYC(GUARD_CYC)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .commit_req (commit_req),
    .commit_ack (commit_ack),
    .blank_mask (blank_mask),
    .seg        (seg),
    .sel        (sel)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // Reference model: predicts the pins registered at this edge
  always @(posedge clk) begin
    exp_t e;
    e.seg = 7'h7F;
    e.sel = 6'h3F;
    e.ack = 1'b0;
    if (rst) begin
      m_st = 0; m_d = 0; m_t = 0; m_pend = 1'b0;
      for (int i = 0; i < 6; i++) begin
        m_sh[i] = 4'h0;
        m_act[i] = 4'h0;
      end
    end else begin
      if (m_st == 0) begin
        e.sel[m_d] = 1'b0;
        if (!blank_mask[m_d]) e.seg = exp_seg(m_act[m_d]);
      end
      if (m_st == 2) e.ack = 1'b1;
      if (wr_en && m_st != 2 && wr_addr < 3'd6) m_sh[wr_addr] = wr_data;
      case (m_st)
        0: begin
          m_t++;
          if (m_t == SCAN_DIV) begin m_st = 1; m_t = 0; end
          m_pend = m_pend | commit_req;
        end
        1: begin
          m_t++;
          if (m_t == GUARD_CYC) begin
            m_t = 0;
            if (m_d == 5) begin
              m_d = 0;
              m_st = m_pend ? 2 : 0;
            end else begin
              m_d++;
              m_st = 0;
            end
          end
          m_pend = m_pend | commit_req;
        end
        default: begin
          for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
          m_pend = commit_req;
          m_st = 0; m_d = 0; m_t = 0;
        end
      endcase
    end
    q.push_back(e);
  end

  // Monitor: compare pins against the scoreboard away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("seg", 32'(seg), 32'(e.seg));
      check("sel", 32'(sel), 32'(e.sel));
      check("commit_ack", 32'(commit_ack), 32'(e.ack));
    end
    check("wr_ready", 32'(wr_ready), 32'(!rst && m_st != 2));
    if (commit_ack === 1'b1) ack_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sel(input string tag, input logic [5:0] pat, input logic [6:0] seg_exp);
    int n = 0;
    @(negedge clk);
    while (sel !== pat && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sel === pat) check(tag, 32'(seg), 32'(seg_exp));
    else check({tag, "_timeout"}, 32'(sel), 32'(pat));
  endtask

  task automatic wait_ack(input string tag, input int base);
    int n = 0;
    while (ack_cnt == base && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(ack_cnt - base), 32'd1);
  endtask

  task automatic wait_model(input string tag, input int st, input int d);
    int n = 0;
    while (!(m_st == st && m_d == d) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check({tag, "_timeout"}, 32'(m_st), 32'(st));
  endtask

  initial begin
    int a0;
    repeat (3) tick();
    rst = 1'b0;
    wait_sel("d0_after_rst", 6'b111110, 7'b0000001);
    wait_sel("d1_after_rst", 6'b111101, 7'b0000001);
    repeat (30) tick();

    // shadow writes without commit: display must not change
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h9; tick();
    wr_addr = 3'd1; wr_data = 4'hA; tick();
    wr_en = 1'b0;
    repeat (90) tick();
    a0 = ack_cnt;
    check("no_ack_without_req", 32'(a0), 32'd0);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    wait_ack("ack_first", a0);
    wait_sel("d0_is_9", 6'b111110, 7'b0000100);
    wait_sel("d1_is_A", 6'b111101, 7'b0001000);

    // held request merges into one commit; write during COMMIT is dropped
    repeat (4) tick();
    a0 = ack_cnt;
    commit_req = 1'b1; repeat (3) tick(); commit_req = 1'b0;
    wait_model("reach_commit", 2, 0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h3; tick();
    wr_en = 1'b0;
    repeat (5) tick();
    check("single_ack", 32'(ack_cnt - a0), 32'd1);

    // illegal address write, then commit; blank digit 2
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'hF; tick();
    wr_en = 1'b0;
    a0 = ack_cnt;
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    wait_ack("ack_third", a0);
    blank_mask = 6'b000100;
    wait_sel("d2_blanked", 6'b111011, 7'h7F);
    wait_sel("d0_kept_9", 6'b111110, 7'b0000100);
    wait_sel("d1_kept_A", 6'b111101, 7'b0001000);
    blank_mask = 6'b000000;

    // reset at digit 3 with a commit pending: everything is lost
    wait_model("reach_d1", 0, 1);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    wait_model("reach_d3", 0, 3);
    rst = 1'b1; tick();
    rst = 1'b0;
    a0 = ack_cnt;
    wait_sel("d0_restart", 6'b111110, 7'b0000001);
    repeat (40) tick();
    check("no_ack_after_rst", 32'(ack_cnt - a0), 32'd0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit drive slot; legal range 2..2^20.
REQ-002 Parameter GUARD_CYC, default 500, all-digits-off cycles between slots; legal range 1..2^16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 wr_en  input  1  shadow digit write strobe.
REQ-006 wr_addr  input  3  shadow digit index; 0..5 valid.
REQ-007 wr_data  input  4  hex digit value.
REQ-008 wr_ready  output  1  high when a write is accepted this cycle.
REQ-009 commit_req  input  1  request to copy shadow digits to active digits.
REQ-010 commit_ack  output  1  one-cycle pulse when the copy is applied.
REQ-011 blank_mask  input  6  bit i high blanks digit i; sampled live.
REQ-012 seg  output  7  active-low segments, bit6=a .. bit0=g, registered.
REQ-013 sel  output  6  active-low digit enables, at most one low, registered.

Function
REQ-014 FSM states SCAN, GUARD, COMMIT; digit index 0..5; prescaler sized for max(SCAN_DIV, GUARD_CYC).
REQ-015 SCAN: drive digit idx for exactly SCAN_DIV cycles, sel bit idx low; then go to GUARD, prescaler to 0.
REQ-016 GUARD: sel=111111, seg=1111111 for exactly GUARD_CYC cycles; then idx advances.
REQ-017 idx advance: 0->1->..->5->0; at 5->0 with commit pending go to COMMIT, else SCAN.
REQ-018 COMMIT lasts one cycle: active[0..5] <= shadow[0..5], commit_ack=1, pending cleared, then SCAN with idx 0.
REQ-019 commit_req high in any cycle sets pending; repeated requests while pending merge into one commit.
REQ-020 commit_req high during the COMMIT cycle re-arms pending for the next frame boundary.
REQ-021 wr_ready=1 in SCAN and GUARD, 0 in COMMIT; wr_en with wr_ready=0 or wr_addr 6/7 is dropped, no side effect.
REQ-022 Accepted write updates shadow[wr_addr] on that edge; active digits never change except in COMMIT.
REQ-023 Decode of active[idx]: 0=0000001,1=1001111,2=0010010,3=0000110,4=1001100,5=0100100,6=0100000,7=0001111,8=0000000,9=0000100,A=0001000,b=1100000,C=0110001,d=1000010,E=0110000,F=0111000.
REQ-024 blank_mask[idx]=1 forces seg=1111111 for that slot, sel unchanged.
REQ-025 seg/sel/commit_ack register the current-cycle state: one cycle latency from state change to pins.
REQ-026 Full frame period = 6*(SCAN_DIV+GUARD_CYC) cycles, plus 1 when a commit occurs.

Reset
REQ-027 rst=1 at clk edge: state SCAN, idx 0, prescaler 0, shadow and active all 0, pending 0.
REQ-028 Outputs during and the cycle after reset: seg=1111111, sel=111111, commit_ack=0; wr_ready=0 while rst=1.
REQ-029 rst mid-slot or mid-COMMIT aborts immediately; pending commit and shadow contents are lost.

Configuration
REQ-030 Macro SEG_SCAN_DP_EN defined: adds input dp_mask[5:0] and registered output dp (active-low), dp=~dp_mask[idx] in SCAN, 1 in GUARD/COMMIT/reset.
REQ-031 Macro undefined: dp_mask and dp ports absent; all other behaviour identical.

Verification (SCAN_DIV=4, GUARD_CYC=1)
REQ-032 Release rst, no writes -> sel 111110 for 4 cycles, 111111 for 1, then 111101; seg=0000001 on every digit.
REQ-033 Write addr0=9, addr1=A, no commit -> display unchanged for 3 frames; then commit_req pulse -> after frame end commit_ack 1 cycle, digit0 seg=0000100, digit1 seg=0001000.
REQ-034 commit_req held high 3 cycles mid-frame -> exactly one commit_ack; wr_en during COMMIT (wr_ready=0) -> shadow unchanged.
REQ-035 Write wr_addr=7 data F, commit -> active digits unchanged; blank_mask=000100 -> digit2 seg=1111111, sel still 111011.
REQ-036 rst asserted while idx=3 with commit pending -> next cycles sel=111111, seg=1111111, no commit_ack, scan restarts at digit 0.
